// File: rtl/sha256_ring_pkg.sv
// Shared definitions for the SHA-256 ring client.
// Holds the block/digest widths and the client state encoding used by
// sha256_ring_client and its word shift register.
package sha256_ring_pkg;

  localparam int sha256_block_width_gp  = 256;
  localparam int sha256_digest_width_gp = 256;

  typedef enum logic [1:0] {
    e_idle,
    e_send,
    e_recv,
    e_done
  } sha256_client_state_e;

endpackage

// File: rtl/sha256_word_shift_reg.sv
// Parallel-load, word-shift register.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset (clears contents)
//   load_i, data_i  parallel load (takes priority over shift)
//   shift_i         shift left by one word, shift_data_i entering at the LSBs
//   data_o          current register contents
module sha256_word_shift_reg
  import sha256_ring_pkg::*;
#(
  parameter int width_p      = sha256_block_width_gp,
  parameter int word_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    load_i,
  input  logic [width_p-1:0]      data_i,
  input  logic                    shift_i,
  input  logic [word_width_p-1:0] shift_data_i,
  output logic [width_p-1:0]      data_o
);

  logic [width_p-1:0] data_r;
  logic [width_p-1:0] shifted;

  // A single-word register has nothing to keep on a shift; the general
  // slice would be empty, so that case is split out.
  generate
    if (word_width_p == width_p) begin : g_one_word
      assign shifted = shift_data_i;
    end else begin : g_multi_word
      assign shifted = {data_r[width_p-word_width_p-1:0], shift_data_i};
    end
  endgenerate

  // NOTE: this is plain flop storage, not a RAM, so it is reset; that keeps
  // ring_data_o and digest_o at zero out of reset and drops partial blocks.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      data_r <= '0;
    else if (load_i)  data_r <= data_i;
    else if (shift_i) data_r <= shifted;
  end

  assign data_o = data_r;

endmodule

// File: rtl/sha256_ring_client.sv
// Initiator-side endpoint for the SHA-256 ring node.
// Accepts one 256-bit block locally, sends it MS word first to the node over
// a valid/ready link, collects the digest words (MS word first) over a
// valid/yumi link and presents the 256-bit digest until the consumer yumis.
// Ports:
//   clk_i, reset_i                     clock, asynchronous active-high reset
//   msg_v_i, msg_i, msg_ready_o        local message in (valid/ready)
//   ring_v_o, ring_data_o, ring_ready_i  ring words to node (valid/ready)
//   ring_v_i, ring_data_i, ring_yumi_o   digest words from node (valid/yumi)
//   digest_v_o, digest_o, digest_yumi_i  local digest out (valid/yumi)
module sha256_ring_client
  import sha256_ring_pkg::*;
#(
  parameter int ring_width_p = 32
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              msg_v_i,
  input  logic [sha256_block_width_gp-1:0]  msg_i,
  output logic                              msg_ready_o,
  output logic                              ring_v_o,
  output logic [ring_width_p-1:0]           ring_data_o,
  input  logic                              ring_ready_i,
  input  logic                              ring_v_i,
  input  logic [ring_width_p-1:0]           ring_data_i,
  output logic                              ring_yumi_o,
  output logic                              digest_v_o,
  output logic [sha256_digest_width_gp-1:0] digest_o,
  input  logic                              digest_yumi_i
);

  localparam int words_lp     = sha256_block_width_gp / ring_width_p;
  localparam int cnt_width_lp = $clog2(words_lp + 1);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(words_lp - 1);

  generate
    if (sha256_block_width_gp % ring_width_p != 0) begin : g_bad_width
      $error("sha256_ring_client: ring_width_p must divide 256");
    end
  endgenerate

  sha256_client_state_e      state_r, state_n;
  logic [cnt_width_lp-1:0]   cnt_r;
  logic [sha256_block_width_gp-1:0]  tx_r;
  logic [sha256_digest_width_gp-1:0] rx_r;

  logic msg_fire, tx_fire, rx_fire, last_word;

  assign msg_fire  = msg_v_i & msg_ready_o;
  assign tx_fire   = ring_v_o & ring_ready_i;
  assign rx_fire   = ring_yumi_o;
  assign last_word = (cnt_r == last_cnt_lp);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  // Next-state logic.
  // NOTE: state_n is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle: if (msg_fire)              state_n = e_send;
      e_send: if (tx_fire && last_word)  state_n = e_recv;
      e_recv: if (rx_fire && last_word)  state_n = e_done;
      e_done: if (digest_yumi_i)         state_n = e_idle;
      default:                           state_n = e_idle;
    endcase
  end

  // Output decode. msg_ready_o is masked by reset so nothing is accepted
  // while the block is being cleared.
  always_comb begin
    msg_ready_o = 1'b0;
    ring_v_o    = 1'b0;
    ring_yumi_o = 1'b0;
    digest_v_o  = 1'b0;
    case (state_r)
      e_idle: msg_ready_o = ~reset_i;
      e_send: ring_v_o    = 1'b1;
      e_recv: ring_yumi_o = ring_v_i;
      e_done: digest_v_o  = 1'b1;
      default: ;
    endcase
  end

  // Word counter: cleared on message accept and on the SEND->RECV hand-off.
  // In RECV it may reach W, which is why it is one bit wider than W-1 needs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r <= '0;
    end else if (msg_fire) begin
      cnt_r <= '0;
    end else if (tx_fire) begin
      cnt_r <= last_word ? '0 : cnt_r + cnt_width_lp'(1);
    end else if (rx_fire) begin
      cnt_r <= cnt_r + cnt_width_lp'(1);
    end
  end

  sha256_word_shift_reg #(
    .width_p     (sha256_block_width_gp),
    .word_width_p(ring_width_p)
  ) tx_sr (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (msg_fire),
    .data_i      (msg_i),
    .shift_i     (tx_fire),
    .shift_data_i('0),
    .data_o      (tx_r)
  );

  sha256_word_shift_reg #(
    .width_p     (sha256_digest_width_gp),
    .word_width_p(ring_width_p)
  ) rx_sr (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (1'b0),
    .data_i      ('0),
    .shift_i     (rx_fire),
    .shift_data_i(ring_data_i),
    .data_o      (rx_r)
  );

  assign ring_data_o = tx_r[sha256_block_width_gp-1 -: ring_width_p];
  assign digest_o    = rx_r;

endmodule

// File: tb/tb_sha256_ring_client.sv
// Directed bench for sha256_ring_client: a 32-bit ring instance for the
// main scenarios and a 256-bit ring instance for the single-word case.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 4 units after the edge (before the falling edge).
module tb_sha256_ring_client;

  typedef struct {
    logic        ready;
    logic [31:0] data;
  } send_vec_t;

  logic clk;
  logic rst;

  // 32-bit ring instance
  logic         msg_v, msg_ready, r_v, ring_ready, in_v, yumi, dig_v, dig_yumi;
  logic [255:0] msg, dig;
  logic [31:0]  r_data, in_data;

  // 256-bit ring instance
  logic         w_msg_v, w_msg_ready, w_r_v, w_ring_ready, w_in_v, w_yumi;
  logic         w_dig_v, w_dig_yumi;
  logic [255:0] w_msg, w_dig, w_r_data, w_in_data;

  int total = 0;
  int bad   = 0;

  sha256_ring_client #(.ring_width_p(32)) dut (
    .clk_i(clk), .reset_i(rst),
    .msg_v_i(msg_v), .msg_i(msg), .msg_ready_o(msg_ready),
    .ring_v_o(r_v), .ring_data_o(r_data), .ring_ready_i(ring_ready),
    .ring_v_i(in_v), .ring_data_i(in_data), .ring_yumi_o(yumi),
    .digest_v_o(dig_v), .digest_o(dig), .digest_yumi_i(dig_yumi)
  );

  sha256_ring_client #(.ring_width_p(256)) dut_w (
    .clk_i(clk), .reset_i(rst),
    .msg_v_i(w_msg_v), .msg_i(w_msg), .msg_ready_o(w_msg_ready),
    .ring_v_o(w_r_v), .ring_data_o(w_r_data), .ring_ready_i(w_ring_ready),
    .ring_v_i(w_in_v), .ring_data_i(w_in_data), .ring_yumi_o(w_yumi),
    .digest_v_o(w_dig_v), .digest_o(w_dig), .digest_yumi_i(w_dig_yumi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [255:0] basic_msg =
    256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [255:0] bp_msg =
    256'hDEADBEEF0123456789ABCDEFCAFEF00D1357924602468ACEFEEDFACE0BADC0DE;
  localparam logic [255:0] exp_digest =
    256'h6A09E667BB67AE853C6EF372A54FF53A510E527F9B05688C1F83D9AB5BE0CD19;

  logic [31:0] resp   [8] = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
                              32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
  logic [31:0] bp_words [8] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D,
                                32'h13579246, 32'h02468ACE, 32'hFEEDFACE, 32'h0BADC0DE};
  logic        bp_pat [14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                               1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  send_vec_t basic_tab [8];
  send_vec_t bp_tab    [14];

  initial begin
    int idx;
    int gap;

    // Expected-value tables.
    for (int i = 0; i < 8; i++) begin
      basic_tab[i].ready = 1'b1;
      basic_tab[i].data  = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    end
    idx = 0;
    for (int i = 0; i < 14; i++) begin
      bp_tab[i].ready = bp_pat[i];
      bp_tab[i].data  = bp_words[idx];
      if (bp_pat[i]) idx++;
    end

    rst = 1'b1;
    msg_v = 0; msg = '0; ring_ready = 0; in_v = 0; in_data = '0; dig_yumi = 0;
    w_msg_v = 0; w_msg = '0; w_ring_ready = 0; w_in_v = 0; w_in_data = '0; w_dig_yumi = 0;

    // ---- Reset state ----
    #3;
    check("rst_msg_ready", msg_ready, 0);
    check("rst_ring_v",    r_v, 0);
    check("rst_ring_data", r_data, 0);
    check("rst_yumi",      yumi, 0);
    check("rst_digest_v",  dig_v, 0);
    check("rst_digest",    dig, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #3;
    check("post_rst_msg_ready", msg_ready, 1);

    // ---- Basic send ----
    next_cycle();
    msg_v = 1; msg = basic_msg;
    #3;
    check("accept_msg_ready", msg_ready, 1);
    next_cycle();
    msg_v = 0;
    for (int i = 0; i < 8; i++) begin
      ring_ready = basic_tab[i].ready;
      #3;
      check($sformatf("basic_v%0d", i),    r_v, 1);
      check($sformatf("basic_data%0d", i), r_data, basic_tab[i].data);
      check($sformatf("basic_rdy%0d", i),  msg_ready, 0);
      next_cycle();
    end
    ring_ready = 0;
    #3;
    check("basic_send_end_v", r_v, 0);
    check("basic_send_end_rdy", msg_ready, 0);

    // ---- Response with random gaps ----
    for (int i = 0; i < 8; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_v = 0; in_data = 32'h0;
        #3;
        check($sformatf("gap_yumi%0d", i), yumi, 0);
        next_cycle();
      end
      in_v = 1; in_data = resp[i];
      #3;
      check($sformatf("resp_yumi%0d", i), yumi, 1);
      check($sformatf("resp_dv%0d", i),   dig_v, 0);
      next_cycle();
    end
    in_v = 0;
    #3;
    check("resp_digest_v", dig_v, 1);
    check("resp_digest",   dig, exp_digest);
    next_cycle();
    // Hold in DONE: new message and stray ring words are ignored.
    for (int i = 0; i < 3; i++) begin
      msg_v = 1; msg = bp_msg; in_v = 1; in_data = 32'h12345678;
      #3;
      check("hold_digest_v", dig_v, 1);
      check("hold_digest",   dig, exp_digest);
      check("hold_msg_ready", msg_ready, 0);
      check("hold_yumi",     yumi, 0);
      next_cycle();
    end
    msg_v = 0; in_v = 0; dig_yumi = 1;
    #3;
    check("yumi_cycle_msg_ready", msg_ready, 0);
    next_cycle();
    dig_yumi = 0;
    #3;
    check("after_yumi_digest_v", dig_v, 0);
    check("after_yumi_msg_ready", msg_ready, 1);

    // ---- Backpressure with a stray response word during SEND ----
    msg_v = 1; msg = bp_msg;
    next_cycle();
    msg_v = 0;
    for (int i = 0; i < 14; i++) begin
      ring_ready = bp_tab[i].ready;
      in_v = 1; in_data = resp[0];
      #3;
      check($sformatf("bp_v%0d", i),    r_v, 1);
      check($sformatf("bp_data%0d", i), r_data, bp_tab[i].data);
      check($sformatf("bp_stray_yumi%0d", i), yumi, 0);
      next_cycle();
    end
    ring_ready = 0;
    #3;
    check("bp_end_v", r_v, 0);
    check("stray_consumed_in_recv", yumi, 1);
    next_cycle();
    for (int i = 1; i < 8; i++) begin
      in_v = 1; in_data = resp[i];
      #3;
      check($sformatf("bp_resp_yumi%0d", i), yumi, 1);
      next_cycle();
    end
    in_v = 0;
    #3;
    check("bp_digest_v", dig_v, 1);
    check("bp_digest",   dig, exp_digest);
    dig_yumi = 1;
    next_cycle();
    dig_yumi = 0;

    // ---- Reset mid-SEND ----
    msg_v = 1; msg = basic_msg;
    #3;
    check("mid_accept_rdy", msg_ready, 1);
    next_cycle();
    msg_v = 0;
    for (int i = 0; i < 3; i++) begin
      ring_ready = 1;
      #3;
      check($sformatf("mid_data%0d", i), r_data, basic_tab[i].data);
      next_cycle();
    end
    ring_ready = 0; in_v = 1; in_data = resp[0]; rst = 1;
    #1;
    check("mid_rst_ring_v",    r_v, 0);
    check("mid_rst_ring_data", r_data, 0);
    check("mid_rst_yumi",      yumi, 0);
    check("mid_rst_digest_v",  dig_v, 0);
    check("mid_rst_digest",    dig, 0);
    check("mid_rst_msg_ready", msg_ready, 0);
    next_cycle();
    rst = 0; in_v = 0;
    #3;
    check("mid_post_rst_rdy", msg_ready, 1);
    next_cycle();
    msg_v = 1; msg = {256{1'b1}};
    next_cycle();
    msg_v = 0;
    for (int i = 0; i < 8; i++) begin
      ring_ready = 1;
      #3;
      check($sformatf("ff_v%0d", i),    r_v, 1);
      check($sformatf("ff_data%0d", i), r_data, 32'hFFFFFFFF);
      next_cycle();
    end
    ring_ready = 0;
    #3;
    check("ff_end_v", r_v, 0);

    // ---- Single-word width (256-bit ring) ----
    w_msg_v = 1; w_msg = basic_msg;
    #3;
    check("w_accept_rdy", w_msg_ready, 1);
    next_cycle();
    w_msg_v = 0; w_ring_ready = 1;
    #3;
    check("w_send_v",    w_r_v, 1);
    check("w_send_data", w_r_data, basic_msg);
    next_cycle();
    w_ring_ready = 0; w_in_v = 1; w_in_data = exp_digest;
    #3;
    check("w_send_done_v", w_r_v, 0);
    check("w_recv_yumi",   w_yumi, 1);
    check("w_recv_dv",     w_dig_v, 0);
    next_cycle();
    w_in_v = 0;
    #3;
    check("w_digest_v", w_dig_v, 1);
    check("w_digest",   w_dig, exp_digest);
    w_dig_yumi = 1;
    next_cycle();
    w_dig_yumi = 0;
    #3;
    check("w_after_yumi_dv",  w_dig_v, 0);
    check("w_after_yumi_rdy", w_msg_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_ring_client.md
# sha256_ring_client

Initiator-side endpoint for the SHA-256 ring node. It takes one 256-bit message block from a local requester and serializes it onto the ring as `ring_width_p`-bit words using a valid/ready handshake into the node. It then collects the node's digest words using a valid/yumi handshake and presents the reassembled 256-bit digest locally. It is the other end of the node's assembler/deassembler pair.

## Interface
Parameters:
- `ring_width_p`, default 32: ring word width. Must divide 256; any other value is an elaboration error.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `msg_v_i`  in  1  local message valid.
- `msg_i`  in  256  message block.
- `msg_ready_o`  out  1  client can accept a message.
- `ring_v_o`  out  1  outgoing ring word valid.
- `ring_data_o`  out  `ring_width_p`  outgoing ring word.
- `ring_ready_i`  in  1  node ready; a word transfers when `ring_v_o & ring_ready_i`.
- `ring_v_i`  in  1  incoming digest word valid.
- `ring_data_i`  in  `ring_width_p`  incoming digest word.
- `ring_yumi_o`  out  1  consume incoming word this cycle.
- `digest_v_o`  out  1  digest valid.
- `digest_o`  out  256  assembled digest.
- `digest_yumi_i`  in  1  local consumer takes the digest.

## Operation
- Words per block: `W = 256/ring_width_p`. Word counter width is `$clog2(W+1)`.
- States:
  - IDLE → SEND on `msg_v_i & msg_ready_o`. `msg_i` is loaded into the tx shift register and the counter is cleared.
  - SEND → RECV on the transfer of word W. The counter is cleared.
  - RECV → DONE on the acceptance of word W.
  - DONE → IDLE on `digest_yumi_i`.
- Transmit order is most-significant word first: `ring_data_o = tx_r[255 -: ring_width_p]`. Each transfer shifts `tx_r` left by `ring_width_p`.
- Receive order is most-significant word first: each accepted word shifts in as `rx_r = {rx_r[255-ring_width_p:0], ring_data_i}`.
- Output decode:
  - `msg_ready_o` = IDLE and not `reset_i`.
  - `ring_v_o` = SEND.
  - `ring_yumi_o` = RECV & `ring_v_i`. This is combinational from `ring_v_i` and is never asserted outside RECV.
  - `digest_v_o` = DONE.
  - `digest_o` = `rx_r`.
- Inputs ignored by state:
  - `msg_v_i` is ignored outside IDLE.
  - `ring_v_i` is ignored outside RECV. Stray words are not consumed, so they remain pending at the node.
  - `digest_yumi_i` is ignored outside DONE.
- `ring_width_p = 256` gives W = 1: SEND and RECV each last exactly one transfer.

## Timing
- Reset (asynchronous):
  - state = IDLE; counter, `tx_r` and `rx_r` = 0.
  - `ring_v_o`, `ring_yumi_o`, `digest_v_o` = 0; `digest_o` = 0; `ring_data_o` = 0.
  - `msg_ready_o` is 0 while `reset_i` is high and 1 in the first cycle after deassertion.
- First ring word is valid the cycle after message acceptance.
- With no stalls:
  - SEND lasts W cycles.
  - RECV lasts W cycles plus node latency.
  - `digest_v_o` rises the cycle after the last word is accepted.
- During a stall in SEND (`ring_ready_i` = 0), `ring_data_o` and the counter hold.
- In DONE, `digest_o` holds stable until `digest_yumi_i`. The next message is accepted no earlier than the cycle after the digest yumi; there is no same-cycle bypass.
- Reset mid-operation aborts the block: partial transmit/receive data is discarded and the next message starts from word 0.

## Structure
- Shared package `sha256_ring_pkg` holds:
  - `localparam sha256_block_width_gp = 256`;
  - `localparam sha256_digest_width_gp = 256`;
  - the state enum `sha256_client_state_e` (IDLE, SEND, RECV, DONE).
- One sub-module is natural: `sha256_word_shift_reg`, a parallel-load, word-shift register parameterized by total and word width. It is instantiated twice, once for tx (parallel load, shift out) and once for rx (shift in, parallel read).

## Test plan
All scenarios use `ring_width_p = 32` unless noted.
- **Basic send:** reset, then `msg_i = 256'h00010203_04050607_..._1C1D1E1F` with `ring_ready_i = 1`.
  - Required: ring words `00010203`, `04050607`, …, `1C1D1E1F` in 8 consecutive cycles.
  - Required: `msg_ready_o = 0` from the acceptance cycle on.
- **Send backpressure:** toggle `ring_ready_i` 1,0,0,1,….
  - Required: `ring_data_o` is stable across stalls and exactly 8 transfers occur, in order.
- **Response:** drive 8 words `6A09E667`, `BB67AE85`, `3C6EF372`, `A54FF53A`, `510E527F`, `9B05688C`, `1F83D9AB`, `5BE0CD19` with random `ring_v_i` gaps.
  - Required: `ring_yumi_o` only with `ring_v_i`.
  - Required: `digest_o = 256'h6A09E667BB67AE85…5BE0CD19`, with `digest_v_o` the cycle after the last word.
  - Required: the digest is held until `digest_yumi_i`, and `msg_ready_o = 1` the next cycle.
- **Stray response during SEND:** assert `ring_v_i` during SEND.
  - Required: `ring_yumi_o = 0`; the word is later consumed in RECV.
- **Reset mid-SEND:** assert reset after 3 words have transferred.
  - Required: all outputs 0 immediately.
  - Required: a new message `0xFF…FF` sends all 8 words `FFFFFFFF` starting from word 0.
- **Single-word width:** with `ring_width_p = 256`, send one word equal to `msg_i` and receive one word.
  - Required: `digest_v_o` the cycle after that word.
